panel_test_ctrl: RTL and testbench

Parametrised board self-test controller, the next generation of the board bring-up top. It replaces the fixed 2-digit, 2-key, 4-LED arrangement and its hard-wired ÷25M divider with one configurable block. The block contains the following functions:
- tick divider
- per-key debouncers
- N-digit BCD up/down counter with mode state machine
- multiplexed 7-segment scan driver
- rotating LED ring

It sits directly under the board top and drives the board pins.

---
 rtl/panel_test_ctrl.sv | 225 ++++++++++++++++++++++
 tb/tb_panel_test_ctrl.sv | 355 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/panel_test_ctrl.sv
// panel_test_ctrl: board self-test controller. Debounces two keys, counts a
// DIGITS-wide BCD value up/down/paused on a divided tick, rotates an LED ring
// and scans the count onto a multiplexed active-low 7-segment display.
module panel_test_ctrl #(
  parameter int DIGITS     = 2,
  parameter int LEDS       = 4,
  parameter int TICK_DIV   = 25000000,
  parameter int SCAN_DIV   = 50000,
  parameter int DEB_CYCLES = 1000000
) (
  input  logic              Sys_CLK,
  input  logic              Sys_RST,
  input  logic [1:0]        Key,
  input  logic [1:0]        Switch,
  output logic [DIGITS-1:0] COM,
  output logic [7:0]        SEG,
  output logic [LEDS-1:0]   LED
);

  localparam int CW = 4 * DIGITS;
  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int DW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [SW-1:0] SCAN_LAST = SW'(SCAN_DIV - 1);
  localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_CYCLES - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);

  typedef enum logic [1:0] {RUN_UP, RUN_DOWN, PAUSE} mode_e;

  logic [1:0]          key_s1_q, key_s2_q, deb_q, press_q;
  logic [1:0][DW-1:0]  deb_cnt_q;
  logic [TW-1:0]       tick_cnt_q;
  logic [SW-1:0]       scan_cnt_q;
  logic [IW-1:0]       idx_q;
  mode_e               mode_q;
  logic [CW-1:0]       bcd_q;
  logic [LEDS-1:0]     ring_q, led_q;
  logic [DIGITS-1:0]   com_q, com_d;
  logic [7:0]          seg_q, seg_d;
  logic [3:0]          digit;
  logic                upper_nz;
  logic                tick, scan_step;

  function automatic logic [7:0] seg_decode(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hFF;
    endcase
    return s;
  endfunction

  // All-9s rolls over to zero because the carry simply runs off the top digit.
  function automatic logic [CW-1:0] bcd_inc(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (carry) begin
        if (v[4*i +: 4] >= 4'd9) begin
          r[4*i +: 4] = 4'd0;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Zero rolls under to all-9s because the borrow runs off the top digit.
  function automatic logic [CW-1:0] bcd_dec(input logic [CW-1:0] v);
    logic [CW-1:0] r;
    logic          borrow;
    r      = v;
    borrow = 1'b1;
    for (int i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (v[4*i +: 4] == 4'd0) begin
          r[4*i +: 4] = 4'd9;
        end else begin
          r[4*i +: 4] = v[4*i +: 4] - 4'd1;
          borrow      = 1'b0;
        end
      end
    end
    return r;
  endfunction

  assign tick      = (tick_cnt_q == TICK_LAST);
  assign scan_step = (scan_cnt_q == SCAN_LAST);

  // Key synchroniser and debouncer; press_q pulses on the accepted 1->0 edge.
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      key_s1_q  <= 2'b11;
      key_s2_q  <= 2'b11;
      deb_q     <= 2'b11;
      press_q   <= 2'b00;
      deb_cnt_q <= '0;
    end else begin
      key_s1_q <= Key;
      key_s2_q <= key_s1_q;
      for (int k = 0; k < 2; k++) begin
        press_q[k] <= 1'b0;
        if (key_s2_q[k] != deb_q[k]) begin
          if (deb_cnt_q[k] == DEB_LAST) begin
            deb_q[k]     <= key_s2_q[k];
            deb_cnt_q[k] <= '0;
            press_q[k]   <= ~key_s2_q[k];
          end else begin
            deb_cnt_q[k] <= deb_cnt_q[k] + DW'(1);
          end
        end else begin
          deb_cnt_q[k] <= '0;
        end
      end
    end
  end

  // Free-running tick divider and digit-scan divider/index.
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      tick_cnt_q <= '0;
      scan_cnt_q <= '0;
      idx_q      <= '0;
    end else begin
      tick_cnt_q <= tick ? '0 : tick_cnt_q + TW'(1);
      scan_cnt_q <= scan_step ? '0 : scan_cnt_q + SW'(1);
      if (scan_step) begin
        idx_q <= (idx_q == IDX_LAST) ? '0 : idx_q + IW'(1);
      end
    end
  end

  // Mode FSM with counter and LED ring; clear overrides a same-cycle tick.
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      mode_q <= RUN_UP;
      bcd_q  <= '0;
      ring_q <= LEDS'(1);
    end else begin
      if (press_q[0]) begin
        case (mode_q)
          RUN_UP:   mode_q <= RUN_DOWN;
          RUN_DOWN: mode_q <= PAUSE;
          default:  mode_q <= RUN_UP;
        endcase
      end
      if (press_q[1]) begin
        bcd_q  <= '0;
        ring_q <= LEDS'(1);
      end else if (tick) begin
        case (mode_q)
          RUN_UP: begin
            bcd_q  <= bcd_inc(bcd_q);
            ring_q <= {ring_q[LEDS-2:0], ring_q[LEDS-1]};
          end
          RUN_DOWN: begin
            bcd_q  <= bcd_dec(bcd_q);
            ring_q <= {ring_q[0], ring_q[LEDS-1:1]};
          end
          default: ;
        endcase
      end
    end
  end

  // Select the scanned digit, apply display mode, blanking and decimal point.
  always_comb begin
    digit    = 4'd0;
    upper_nz = 1'b0;
    com_d    = '1;
    seg_d    = 8'hFF;
    for (int i = 0; i < DIGITS; i++) begin
      if (IW'(i) == idx_q) begin
        digit    = bcd_q[4*i +: 4];
        com_d[i] = 1'b0;
      end
      if ((IW'(i) >= idx_q) && (bcd_q[4*i +: 4] != 4'd0)) begin
        upper_nz = 1'b1;
      end
    end
    case (Switch)
      2'b00:   seg_d = seg_decode(digit);
      2'b01:   seg_d = ((idx_q != '0) && !upper_nz) ? 8'hFF : seg_decode(digit);
      2'b10:   seg_d = 8'h00;
      default: seg_d = 8'hFF;
    endcase
    if ((mode_q == PAUSE) && !Switch[1] && (idx_q == '0)) begin
      seg_d[7] = 1'b0;
    end
  end

  // COM and SEG share one register stage so digit select and data stay paired.
  always_ff @(posedge Sys_CLK) begin
    if (!Sys_RST) begin
      com_q <= '1;
      seg_q <= 8'hFF;
      led_q <= '0;
    end else begin
      com_q <= com_d;
      seg_q <= seg_d;
      led_q <= ring_q;
    end
  end

  assign COM = com_q;
  assign SEG = seg_q;
  assign LED = led_q;

endmodule

// File: tb/tb_panel_test_ctrl.sv
// Bench for panel_test_ctrl: an integer-level reference model (count as a
// number mod 100, ring as a rotated int, debounce as a sample window) predicts
// COM/SEG/LED every cycle; scenario tasks add fixed expectations.
module tb_panel_test_ctrl;
  localparam int DIGITS     = 2;
  localparam int LEDS       = 4;
  localparam int TICK_DIV   = 4;
  localparam int SCAN_DIV   = 3;
  localparam int DEB_CYCLES = 5;
  localparam int MOD        = 100;

  logic              clk   = 1'b0;
  logic              rst_n = 1'b0;
  logic [1:0]        key   = 2'b11;
  logic [1:0]        sw    = 2'b00;
  logic [DIGITS-1:0] com;
  logic [7:0]        seg;
  logic [LEDS-1:0]   led;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  panel_test_ctrl #(
    .DIGITS(DIGITS), .LEDS(LEDS), .TICK_DIV(TICK_DIV),
    .SCAN_DIV(SCAN_DIV), .DEB_CYCLES(DEB_CYCLES)
  ) dut (
    .Sys_CLK(clk), .Sys_RST(rst_n), .Key(key), .Switch(sw),
    .COM(com), .SEG(seg), .LED(led)
  );

  logic [7:0] dec_tab [10] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99,
                               8'h92, 8'h82, 8'hF8, 8'h80, 8'h90};

  int                m_ncyc  = 0;
  int                m_count = 0;
  int                m_ring  = 1;
  int                m_mode  = 0;
  logic [1:0]        m_deb   = 2'b11;
  logic [1:0]        m_ev    = 2'b00;
  logic [1:0]        m_hist[$];
  logic [DIGITS-1:0] e_com   = '1;
  logic [7:0]        e_seg   = 8'hFF;
  logic [LEDS-1:0]   e_led   = '0;
  bit                m_clr_tick = 1'b0;

  function automatic logic [7:0] model_seg(input int count, input int idx,
                                           input logic [1:0] s, input int mode);
    int p;
    logic [7:0] r;
    p = 1;
    for (int i = 0; i < idx; i++) p = p * 10;
    if (s == 2'b10) r = 8'h00;
    else if (s == 2'b11) r = 8'hFF;
    else begin
      if (s == 2'b01 && idx > 0 && count < p) r = 8'hFF;
      else r = dec_tab[(count / p) % 10];
      if (mode == 2 && idx == 0) r[7] = 1'b0;
    end
    return r;
  endfunction

  task automatic model_edge();
    int idx;
    bit tick;
    bit all_diff;
    logic [1:0] nev;
    if (!rst_n) begin
      m_ncyc = 0; m_count = 0; m_ring = 1; m_mode = 0;
      m_deb = 2'b11; m_ev = 2'b00;
      m_hist.delete();
      for (int j = 0; j < DEB_CYCLES + 2; j++) m_hist.push_back(2'b11);
      e_com = '1; e_seg = 8'hFF; e_led = '0;
    end else begin
      idx   = (m_ncyc / SCAN_DIV) % DIGITS;
      e_com = '1;
      e_com[idx] = 1'b0;
      e_seg = model_seg(m_count, idx, sw, m_mode);
      e_led = LEDS'(m_ring);
      tick  = (m_ncyc % TICK_DIV) == TICK_DIV - 1;
      if (m_ev[1]) begin
        if (tick) m_clr_tick = 1'b1;
        m_count = 0;
        m_ring  = 1;
      end else if (tick && m_mode == 0) begin
        m_count = (m_count + 1) % MOD;
        m_ring  = ((m_ring << 1) | (m_ring >> (LEDS - 1))) & ((1 << LEDS) - 1);
      end else if (tick && m_mode == 1) begin
        m_count = (m_count + MOD - 1) % MOD;
        m_ring  = (m_ring >> 1) | ((m_ring & 1) << (LEDS - 1));
      end
      if (m_ev[0]) m_mode = (m_mode + 1) % 3;
      nev = 2'b00;
      for (int k = 0; k < 2; k++) begin
        all_diff = 1'b1;
        for (int j = 1; j <= DEB_CYCLES; j++)
          if (m_hist[j][k] == m_deb[k]) all_diff = 1'b0;
        if (all_diff) begin
          m_deb[k] = m_hist[1][k];
          if (m_deb[k] == 1'b0) nev[k] = 1'b1;
        end
      end
      m_ev = nev;
      m_hist.push_front(key);
      void'(m_hist.pop_back());
      m_ncyc++;
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; key = 2'b11; sw = 2'b00;
    for (int i = 0; i < 3; i++) begin
      cycle();
      n_checks++;
      if ({com, seg, led} !== {2'b11, 8'hFF, 4'h0}) begin
        n_errors++;
        $display("FAIL reset_outputs: got COM=%b SEG=%h LED=%b, expected 11 FF 0000", com, seg, led);
      end
    end
    rst_n = 1'b1;
    cycle();
    n_checks++;
    if ({com, seg, led} !== {2'b10, 8'hC0, 4'b0001}) begin
      n_errors++;
      $display("FAIL first_after_reset: got COM=%b SEG=%h LED=%b, expected 10 C0 0001", com, seg, led);
    end
    for (int i = 0; i < 30; i++) begin
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL post_reset: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
    end
  endtask

  task automatic test_wrap_up();
    int prev;
    bit seen;
    int after;
    seen = 1'b0; after = 0;
    for (int i = 0; i < 600 && after < 12; i++) begin
      prev = m_count;
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL wrap_up: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
      if (seen) after++;
      if (prev == MOD - 1 && m_count == 0) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL wrap_up_timeout: got no 99->00 wrap within budget, expected one");
    end
  endtask

  task automatic test_clear_on_tick();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 400 && !found; i++) begin
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL clear_lead: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
      if (m_count == 36 && m_mode == 0 && (m_ncyc % TICK_DIV) == 0) found = 1'b1;
    end
    n_checks++;
    if (!found) begin
      n_errors++;
      $display("FAIL clear_setup_timeout: got no count 36 alignment, expected one");
    end
    m_clr_tick = 1'b0;
    key[1] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (i == 8) key[1] = 1'b1;
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL clear_on_tick: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
    end
    n_checks++;
    if (m_clr_tick !== 1'b1) begin
      n_errors++;
      $display("FAIL clear_tick_align: got coincidence=%0d, expected 1", m_clr_tick);
    end
  endtask

  task automatic test_debounce_mode();
    int prev;
    bit seen;
    int after;
    key[0] = 1'b0;
    for (int i = 0; i < 23; i++) begin
      if (i == 3) key[0] = 1'b1;
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL bounce_ignored: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
    end
    key[0] = 1'b0;
    seen = 1'b0; after = 0;
    for (int i = 0; i < 400 && after < 8; i++) begin
      if (i == 10) key[0] = 1'b1;
      prev = m_count;
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL run_down: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
      if (seen) after++;
      if (prev == 0 && m_count == MOD - 1) seen = 1'b1;
    end
    n_checks++;
    if (!seen) begin
      n_errors++;
      $display("FAIL down_wrap_timeout: got no 00->99 wrap within budget, expected one");
    end
  endtask

  task automatic test_dual_event();
    key = 2'b00;
    for (int i = 0; i < 25; i++) begin
      if (i == 10) key = 2'b11;
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL dual_event: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
    end
  endtask

  task automatic test_pause();
    logic [7:0] exp_seg;
    for (int i = 0; i < 16; i++) begin
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL pause_model: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
      exp_seg = (com == 2'b10) ? 8'h40 : 8'hC0;
      n_checks++;
      if (seg !== exp_seg || led !== 4'b0001) begin
        n_errors++;
        $display("FAIL pause_dp: got COM=%b SEG=%h LED=%b, expected SEG=%h LED=0001", com, seg, led, exp_seg);
      end
    end
    key[0] = 1'b0;
    for (int i = 0; i < 18; i++) begin
      if (i == 8) key[0] = 1'b1;
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL pause_resume: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
    end
  endtask

  task automatic test_display();
    for (int s = 0; s < 4; s++) begin
      sw = 2'(s);
      for (int j = 0; j < 9; j++) begin
        cycle();
        n_checks++;
        if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
          n_errors++;
          $display("FAIL display_sw%0d: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", s, com, seg, led, e_com, e_seg, e_led);
        end
        if (s >= 2) begin
          n_checks++;
          if (seg !== ((s == 2) ? 8'h00 : 8'hFF) || !(com == 2'b10 || com == 2'b01)) begin
            n_errors++;
            $display("FAIL display_fixed_sw%0d: got COM=%b SEG=%h, expected one-hot-low COM and SEG=%h", s, com, seg, (s == 2) ? 8'h00 : 8'hFF);
          end
        end
      end
    end
    sw = 2'b00;
  endtask

  task automatic test_reset_mid();
    key[0] = 1'b0;
    for (int i = 0; i < 4; i++) cycle();
    rst_n = 1'b0;
    key = 2'b11;
    for (int i = 0; i < 2; i++) begin
      cycle();
      n_checks++;
      if ({com, seg, led} !== {2'b11, 8'hFF, 4'h0}) begin
        n_errors++;
        $display("FAIL reset_mid: got COM=%b SEG=%h LED=%b, expected 11 FF 0000", com, seg, led);
      end
    end
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      n_checks++;
      if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
        n_errors++;
        $display("FAIL after_reset_mid: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
      end
    end
  endtask

  task automatic test_random();
    int len;
    for (int n = 0; n < 90; n++) begin
      key = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 3) == 0) sw = 2'($urandom_range(0, 3));
      len = $urandom_range(1, 12);
      for (int i = 0; i < len; i++) begin
        cycle();
        n_checks++;
        if ({com, seg, led} !== {e_com, e_seg, e_led}) begin
          n_errors++;
          $display("FAIL random: got COM=%b SEG=%h LED=%b, expected COM=%b SEG=%h LED=%b", com, seg, led, e_com, e_seg, e_led);
        end
      end
    end
    key = 2'b11;
  endtask

  initial begin
    test_reset();
    test_wrap_up();
    test_clear_on_tick();
    test_debounce_mode();
    test_dual_event();
    test_pause();
    test_display();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
